// File: rtl/if_stage_ctrl.sv
// Fetch-side pipeline controller: owns the PC and the IF/ID register, and resolves
// reset > flush > stall > fetch-wait > advance into PC, IF/ID, bubble and counter updates.
module if_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_signal,
  input  logic             EX_branch_taken,
  input  logic [31:0]      EX_branch_target,
  input  logic             imem_ready,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      IF_pc,
  output logic [31:0]      ID_pc,
  output logic [31:0]      ID_instr,
  output logic             ID_valid,
  output logic             IDEX_bubble,
  output logic             IFID_flush_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_STALL,
    ACT_WAIT,
    ACT_ADV
  } act_t;

  // Fetch addresses are word aligned; the low two bits are never driven to memory.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  logic [31:0]      r_if_pc_p0;
  logic [31:0]      r_id_pc_p1;
  logic [31:0]      r_id_instr_p1;
  logic             r_vld_p1;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  act_t             w_act;
  logic [31:0]      w_if_pc_nxt;
  logic [31:0]      w_id_pc_nxt;
  logic [31:0]      w_id_instr_nxt;
  logic             w_vld_nxt;
  logic [CNT_W-1:0] w_stall_cnt_nxt;
  logic [CNT_W-1:0] w_flush_cnt_nxt;
  logic             w_bubble;
  logic             w_flush;

  // Single priority decode; every downstream update keys off this one action.
  always_comb begin
    w_act = ACT_ADV;
    if (rst) begin
      w_act = ACT_RESET;
    end else if (EX_branch_taken) begin
      w_act = ACT_FLUSH;
    end else if (stall_signal) begin
      w_act = ACT_STALL;
    end else if (!imem_ready) begin
      w_act = ACT_WAIT;
    end
  end

  assign w_flush  = (w_act == ACT_FLUSH);
  assign w_bubble = (w_act == ACT_FLUSH) || (w_act == ACT_STALL);

  always_comb begin
    w_if_pc_nxt     = r_if_pc_p0;
    w_id_pc_nxt     = r_id_pc_p1;
    w_id_instr_nxt  = r_id_instr_p1;
    w_vld_nxt       = r_vld_p1;
    w_stall_cnt_nxt = r_stall_cnt;
    w_flush_cnt_nxt = r_flush_cnt;
    case (w_act)
      ACT_RESET: begin
        w_if_pc_nxt     = align_pc(RESET_PC);
        w_id_pc_nxt     = 32'h0;
        w_id_instr_nxt  = NOP_INSTR;
        w_vld_nxt       = 1'b0;
        w_stall_cnt_nxt = '0;
        w_flush_cnt_nxt = '0;
      end
      ACT_FLUSH: begin
        w_if_pc_nxt     = align_pc(EX_branch_target);
        w_id_pc_nxt     = 32'h0;
        w_id_instr_nxt  = NOP_INSTR;
        w_vld_nxt       = 1'b0;
        w_flush_cnt_nxt = sat_inc(r_flush_cnt);
      end
      ACT_STALL: begin
        // PC and IF/ID hold so the same address is refetched next cycle.
        w_stall_cnt_nxt = sat_inc(r_stall_cnt);
      end
      ACT_WAIT: begin
        // ID_pc is left untouched; only the instruction slot is invalidated.
        w_id_instr_nxt  = NOP_INSTR;
        w_vld_nxt       = 1'b0;
      end
      ACT_ADV: begin
        w_if_pc_nxt     = r_if_pc_p0 + 32'd4;
        w_id_pc_nxt     = r_if_pc_p0;
        w_id_instr_nxt  = imem_instr;
        w_vld_nxt       = 1'b1;
      end
      default: begin
        w_if_pc_nxt     = r_if_pc_p0;
      end
    endcase
  end

  // IF -> ID boundary: PC register feeds the IF/ID register on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_pc_p0    <= align_pc(RESET_PC);
      r_id_pc_p1    <= 32'h0;
      r_id_instr_p1 <= NOP_INSTR;
      r_vld_p1      <= 1'b0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      r_if_pc_p0    <= w_if_pc_nxt;
      r_id_pc_p1    <= w_id_pc_nxt;
      r_id_instr_p1 <= w_id_instr_nxt;
      r_vld_p1      <= w_vld_nxt;
      r_stall_cnt   <= w_stall_cnt_nxt;
      r_flush_cnt   <= w_flush_cnt_nxt;
    end
  end

  assign IF_pc        = r_if_pc_p0;
  assign ID_pc        = r_id_pc_p1;
  assign ID_instr     = r_id_instr_p1;
  assign ID_valid     = r_vld_p1;
  assign IDEX_bubble  = w_bubble;
  assign IFID_flush_o = w_flush;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Bench for if_stage_ctrl: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a priority-rule reference model.
module tb_if_stage_ctrl;

  localparam int CW = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst, stall_signal, EX_branch_taken, imem_ready;
  logic [31:0]   EX_branch_target, imem_instr;
  logic [31:0]   IF_pc, ID_pc, ID_instr;
  logic          ID_valid, IDEX_bubble, IFID_flush_o;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  logic [31:0] m_pc, m_idpc, m_instr;
  logic        m_v;
  int          m_sc, m_fc;
  bit          m_known = 0;

  if_stage_ctrl #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall_signal(stall_signal),
    .EX_branch_taken(EX_branch_taken), .EX_branch_target(EX_branch_target),
    .imem_ready(imem_ready), .imem_instr(imem_instr),
    .IF_pc(IF_pc), .ID_pc(ID_pc), .ID_instr(ID_instr), .ID_valid(ID_valid),
    .IDEX_bubble(IDEX_bubble), .IFID_flush_o(IFID_flush_o),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, s, b, input logic [31:0] t,
                            input logic rd, input logic [31:0] ins);
    if (r) begin
      m_pc = 32'h0; m_idpc = 32'h0; m_instr = NOP; m_v = 1'b0;
      m_sc = 0; m_fc = 0; m_known = 1;
    end else if (b) begin
      m_pc = {t[31:2], 2'b00}; m_idpc = 32'h0; m_instr = NOP; m_v = 1'b0;
      if (m_fc < (1 << CW) - 1) m_fc++;
    end else if (s) begin
      if (m_sc < (1 << CW) - 1) m_sc++;
    end else if (!rd) begin
      m_instr = NOP; m_v = 1'b0;
    end else begin
      m_idpc = m_pc; m_instr = ins; m_v = 1'b1;
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_regs();
    if (m_known) begin
      chk("IF_pc", IF_pc, m_pc);
      chk("ID_pc", ID_pc, m_idpc);
      chk("ID_instr", ID_instr, m_instr);
      chk("ID_valid", 32'(ID_valid), 32'(m_v));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_sc));
      chk("flush_cnt", 32'(flush_cnt), 32'(m_fc));
    end
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check registers.
  task automatic cyc(input logic r, s, b, input logic [31:0] t,
                     input logic rd, input logic [31:0] ins);
    @(negedge clk);
    rst = r; stall_signal = s; EX_branch_taken = b; EX_branch_target = t;
    imem_ready = rd; imem_instr = ins;
    #1;
    chk("IDEX_bubble", 32'(IDEX_bubble), 32'(!r && (b || s)));
    chk("IFID_flush_o", 32'(IFID_flush_o), 32'(!r && b));
    @(posedge clk);
    model_step(r, s, b, t, rd, ins);
    #1;
    check_regs();
  endtask

  initial begin
    logic r, s, b, rd;
    logic [31:0] t, ins;

    rst = 1'b1; stall_signal = 1'b0; EX_branch_taken = 1'b0;
    EX_branch_target = 32'h0; imem_ready = 1'b0; imem_instr = 32'h0;

    // Reset with stall and branch asserted
    cyc(1, 1, 1, 32'h200, 1, 32'hDEAD_BEEF);
    cyc(1, 1, 1, 32'h200, 1, 32'hDEAD_BEEF);
    chk("rst_pc", IF_pc, 32'h0);
    chk("rst_instr", ID_instr, 32'h13);
    chk("rst_valid", 32'(ID_valid), 32'h0);

    // Straight-line fetch A,B
    cyc(0, 0, 0, 0, 1, 32'hA);
    chk("sl_A_pc", ID_pc, 32'h0);
    chk("sl_if4", IF_pc, 32'h4);
    cyc(0, 0, 0, 0, 1, 32'hB);
    chk("sl_B", ID_instr, 32'hB);
    // Load-use stall with B in ID
    cyc(0, 1, 0, 0, 1, 32'hC);
    chk("st_pc", IF_pc, 32'h8);
    chk("st_hold", ID_pc, 32'h4);
    chk("st_cnt", 32'(stall_cnt), 32'h1);
    cyc(0, 0, 0, 0, 1, 32'hC);
    chk("st_C", ID_instr, 32'hC);
    cyc(0, 0, 0, 0, 1, 32'hD);
    chk("sl_D_pc", ID_pc, 32'hC);
    chk("sl_if10", IF_pc, 32'h10);

    // Flush over stall
    cyc(0, 1, 1, 32'h100, 1, 32'hE);
    chk("fl_pc", IF_pc, 32'h100);
    chk("fl_cnt", 32'(flush_cnt), 32'h1);
    chk("fl_scnt", 32'(stall_cnt), 32'h1);

    // Misaligned redirect to the top of memory, then fetch-wait and wrap
    cyc(0, 0, 1, 32'hFFFF_FFFE, 1, 32'hE);
    chk("mis_pc", IF_pc, 32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 32'h77);
    chk("fw_pc", IF_pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 1, 32'h1234_5678);
    chk("wrap_pc", IF_pc, 32'h0);
    chk("wrap_id", ID_pc, 32'hFFFF_FFFC);

    // Back-to-back flushes: last target wins
    cyc(0, 0, 1, 32'h300, 1, 0);
    cyc(0, 0, 1, 32'h400, 1, 0);
    chk("b2b_pc", IF_pc, 32'h400);

    // Stall saturation
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 1, 32'h5);
    chk("sat_stall", 32'(stall_cnt), 32'hF);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      b   = ($urandom_range(0, 99) < 12);
      s   = ($urandom_range(0, 99) < 20);
      rd  = ($urandom_range(0, 99) < 75);
      t   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom();
      ins = $urandom();
      cyc(r, s, b, t, rd, ins);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
